// File: rtl/lsu_mem_stage.sv
// RV32I load/store memory stage: issues one req/gnt/rvalid data-memory access per
// start and returns an aligned, extended load result with a one-cycle done pulse.
module lsu_mem_stage #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_store,
    input  logic [2:0]           funct3,
    input  logic [WORD_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] store_data,
    output logic                 busy,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic [3:0]           mem_be,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic [WORD_SIZE-1:0] load_data,
    output logic                 done,
    output logic                 misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

    state_t               state_reg, state_next;
    logic                 store_reg, store_next;
    logic [2:0]           funct3_reg, funct3_next;
    logic [1:0]           off_reg, off_next;
    logic                 mem_req_reg, mem_req_next;
    logic                 mem_we_reg, mem_we_next;
    logic [WORD_SIZE-1:0] mem_addr_reg, mem_addr_next;
    logic [WORD_SIZE-1:0] mem_wdata_reg, mem_wdata_next;
    logic [3:0]           mem_be_reg, mem_be_next;
    logic [WORD_SIZE-1:0] load_data_reg, load_data_next;
    logic                 done_reg, done_next;
    logic                 misaligned_reg, misaligned_next;

    logic [7:0]           rd_byte [4];
    logic [WORD_SIZE-1:0] wdata_b, wdata_h;
    logic [7:0]           sel_byte;
    logic [15:0]          sel_half;
    logic [WORD_SIZE-1:0] load_ext;
    logic                 illegal;
    logic [3:0]           store_be;
    logic [WORD_SIZE-1:0] store_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lanes
            assign rd_byte[gi]          = mem_rdata[8*gi +: 8];
            assign wdata_b[8*gi +: 8]   = store_data[7:0];
        end
        for (gi = 0; gi < 2; gi++) begin : g_halves
            assign wdata_h[16*gi +: 16] = store_data[15:0];
        end
    endgenerate

    assign sel_byte = rd_byte[off_reg];
    assign sel_half = off_reg[1] ? {rd_byte[3], rd_byte[2]} : {rd_byte[1], rd_byte[0]};

    always_comb begin
        load_ext = mem_rdata;
        case (funct3_reg)
            3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_ext = {24'd0, sel_byte};
            3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_ext = {16'd0, sel_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // Rejected accesses never reach memory: bad funct3, unsigned stores, unaligned H/W.
    always_comb begin
        illegal = 1'b0;
        if (funct3 == 3'b011 || funct3[2:1] == 2'b11)
            illegal = 1'b1;
        else if (is_store && funct3[2])
            illegal = 1'b1;
        else if (funct3[1:0] == 2'b01 && addr[0])
            illegal = 1'b1;
        else if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
            illegal = 1'b1;
    end

    always_comb begin
        store_be    = 4'b1111;
        store_wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                store_be    = 4'b0001 << addr[1:0];
                store_wdata = wdata_b;
            end
            2'b01: begin
                store_be    = addr[1] ? 4'b1100 : 4'b0011;
                store_wdata = wdata_h;
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = store_data;
            end
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        store_next      = store_reg;
        funct3_next     = funct3_reg;
        off_next        = off_reg;
        mem_req_next    = mem_req_reg;
        mem_we_next     = mem_we_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        mem_be_next     = mem_be_reg;
        load_data_next  = load_data_reg;
        done_next       = 1'b0;
        misaligned_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (illegal) begin
                        misaligned_next = 1'b1;
                    end else begin
                        store_next     = is_store;
                        funct3_next    = funct3;
                        off_next       = addr[1:0];
                        mem_req_next   = 1'b1;
                        mem_we_next    = is_store;
                        mem_addr_next  = {addr[WORD_SIZE-1:2], 2'b00};
                        mem_be_next    = is_store ? store_be : 4'b1111;
                        mem_wdata_next = is_store ? store_wdata : '0;
                        state_next     = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    mem_req_next = 1'b0;
                    mem_we_next  = 1'b0;
                    if (store_reg) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT_R;
                    end
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    load_data_next = load_ext;
                    done_next      = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            store_reg      <= 1'b0;
            funct3_reg     <= 3'b000;
            off_reg        <= 2'b00;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_be_reg     <= 4'b0000;
            load_data_reg  <= '0;
            done_reg       <= 1'b0;
            misaligned_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            store_reg      <= store_next;
            funct3_reg     <= funct3_next;
            off_reg        <= off_next;
            mem_req_reg    <= mem_req_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            mem_be_reg     <= mem_be_next;
            load_data_reg  <= load_data_next;
            done_reg       <= done_next;
            misaligned_reg <= misaligned_next;
        end
    end

    assign busy       = (state_reg != IDLE);
    assign mem_req    = mem_req_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign mem_be     = mem_be_reg;
    assign load_data  = load_data_reg;
    assign done       = done_reg;
    assign misaligned = misaligned_reg;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized bench for lsu_mem_stage; expectations come from an arithmetic model
// of RV32I load/store lane rules, compared cycle by cycle against the DUT.
module tb_lsu_mem_stage;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] load_data;
    logic        done;
    logic        misaligned;

    int          total = 0;
    int          bad = 0;
    logic [31:0] model_ld = 32'd0;

    lsu_mem_stage #(.WORD_SIZE(32)) dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .load_data(load_data),
        .done(done), .misaligned(misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int size;
        if (f3 == 3'd3 || f3 >= 3'd6) return 1'b0;
        if (st && f3 >= 3'd4) return 1'b0;
        size = 1 << (f3 % 4);
        return (a % size) == 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * (a % 4));
        case (f3)
            3'd0:    return ((v & 32'hFF) >= 32'd128) ? ((v & 32'hFF) | 32'hFFFFFF00) : (v & 32'hFF);
            3'd4:    return v & 32'hFF;
            3'd1:    return ((v & 32'hFFFF) >= 32'd32768) ? ((v & 32'hFFFF) | 32'hFFFF0000) : (v & 32'hFFFF);
            3'd5:    return v & 32'hFFFF;
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int size;
        size = 1 << (f3 % 4);
        return 32'(((1 << size) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
        if (f3 == 3'd0) return (sd % 256) * 32'h01010101;
        if (f3 == 3'd1) return (sd % 65536) * 32'h00010001;
        return sd;
    endfunction

    // One memory operation; a legal store returns in its done cycle so the next call
    // can start back-to-back.
    task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd,
                         input int gd, input int rdl, input bit pester);
        bit          ok;
        logic [31:0] exp_addr, exp_be, exp_wd, exp_ld;
        ok       = legal(st, f3, a);
        exp_addr = a & 32'hFFFFFFFC;
        exp_be   = st ? model_be(f3, a) : 32'hF;
        exp_wd   = model_wdata(f3, sd);
        is_store = st; funct3 = f3; addr = a; store_data = sd; start = 1'b1;
        tick();
        start = 1'b0;
        check("done_after_start", {31'd0, done}, 32'd0);
        if (!ok) begin
            check("misal_pulse", {31'd0, misaligned}, 32'd1);
            check("misal_noreq", {31'd0, mem_req}, 32'd0);
            check("misal_busy", {31'd0, busy}, 32'd0);
            tick();
            check("misal_clear", {31'd0, misaligned}, 32'd0);
            check("misal_noreq2", {31'd0, mem_req}, 32'd0);
            check("misal_nodone", {31'd0, done}, 32'd0);
            $display("op st=%0d f3=%03b addr=%08h rejected", st, f3, a);
            return;
        end
        check("misal_low", {31'd0, misaligned}, 32'd0);
        check("req_up", {31'd0, mem_req}, 32'd1);
        check("busy_req", {31'd0, busy}, 32'd1);
        check("we", {31'd0, mem_we}, {31'd0, st});
        check("maddr", mem_addr, exp_addr);
        check("be", {28'd0, mem_be}, exp_be);
        if (st) check("wdata", mem_wdata, exp_wd);
        check("ld_held", load_data, model_ld);
        for (int i = 0; i < gd; i++) begin
            if (pester) begin
                start = 1'b1; addr = $urandom; is_store = $urandom_range(0, 1);
                funct3 = 3'($urandom_range(0, 7)); store_data = $urandom;
                mem_rvalid = 1'b1; mem_rdata = $urandom;
            end
            tick();
            check("req_hold", {31'd0, mem_req}, 32'd1);
            check("maddr_hold", mem_addr, exp_addr);
            check("be_hold", {28'd0, mem_be}, exp_be);
            if (st) check("wdata_hold", mem_wdata, exp_wd);
            check("done_wait_gnt", {31'd0, done}, 32'd0);
        end
        mem_rvalid = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        start = 1'b0;
        if (st) begin
            check("st_done", {31'd0, done}, 32'd1);
            check("st_req_drop", {31'd0, mem_req}, 32'd0);
            check("st_idle", {31'd0, busy}, 32'd0);
            check("st_nomisal", {31'd0, misaligned}, 32'd0);
            $display("op store f3=%03b addr=%08h data=%08h gnt_delay=%0d", f3, a, sd, gd);
            return;
        end
        check("ld_req_drop", {31'd0, mem_req}, 32'd0);
        check("ld_busy", {31'd0, busy}, 32'd1);
        check("ld_nodone", {31'd0, done}, 32'd0);
        for (int i = 0; i < rdl; i++) begin
            start = pester;
            tick();
            check("wr_busy", {31'd0, busy}, 32'd1);
            check("wr_nodone", {31'd0, done}, 32'd0);
            check("wr_noreq", {31'd0, mem_req}, 32'd0);
        end
        mem_rvalid = 1'b1; mem_rdata = rd;
        tick();
        mem_rvalid = 1'b0; start = 1'b0;
        exp_ld   = model_load(f3, a, rd);
        model_ld = exp_ld;
        check("ld_done", {31'd0, done}, 32'd1);
        check("ld_data", load_data, exp_ld);
        check("ld_idle", {31'd0, busy}, 32'd0);
        $display("op load f3=%03b addr=%08h rdata=%08h -> %08h", f3, a, rd, exp_ld);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, {31'd0, mem_req}, 32'd0);
        check({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_addr"}, mem_addr, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_be"}, {28'd0, mem_be}, 32'd0);
        check({tag, "_ld"}, load_data, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_misal"}, {31'd0, misaligned}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [2:0] f3_pick [5];
        f3_pick[0] = 3'd0; f3_pick[1] = 3'd1; f3_pick[2] = 3'd2;
        f3_pick[3] = 3'd4; f3_pick[4] = 3'd5;
        reset = 1'b0; start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'd0;
        store_data = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (3) tick();
        check_all_zero("reset");
        start = 1'b0;
        reset = 1'b1;
        tick();
        check("post_reset_noreq", {31'd0, mem_req}, 32'd0);
        $display("reset released");

        do_op(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'd0, 3, 0, 1'b1);
        do_op(1'b1, 3'd0, 32'h203, 32'h000000A5, 32'd0, 0, 0, 1'b0);
        do_op(1'b1, 3'd1, 32'h202, 32'h00001234, 32'd0, 1, 0, 1'b0);
        do_op(1'b0, 3'd0, 32'h303, 32'd0, 32'h80F07F01, 0, 5, 1'b1);
        do_op(1'b0, 3'd4, 32'h303, 32'd0, 32'h80F07F01, 1, 0, 1'b0);
        do_op(1'b0, 3'd1, 32'h302, 32'd0, 32'h80F07F01, 0, 2, 1'b0);
        do_op(1'b0, 3'd5, 32'h300, 32'd0, 32'h80F07F01, 2, 1, 1'b0);
        do_op(1'b0, 3'd2, 32'h300, 32'd0, 32'h80F07F01, 0, 5, 1'b1);
        do_op(1'b0, 3'd2, 32'h102, 32'd0, 32'd0, 0, 0, 1'b0);
        do_op(1'b1, 3'd1, 32'h101, 32'h1234, 32'd0, 0, 0, 1'b0);
        do_op(1'b0, 3'd3, 32'h000, 32'd0, 32'd0, 0, 0, 1'b0);
        do_op(1'b1, 3'd4, 32'h000, 32'd0, 32'd0, 0, 0, 1'b0);

        // Async reset while a request is outstanding: mem_req must fall before any edge.
        is_store = 1'b0; funct3 = 3'd2; addr = 32'h40; start = 1'b1;
        tick();
        start = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async_req_drop", {31'd0, mem_req}, 32'd0);
        check("async_busy", {31'd0, busy}, 32'd0);
        model_ld = 32'd0;
        tick();
        reset = 1'b1;
        $display("reset during REQ");

        do_op(1'b0, 3'd2, 32'h80, 32'd0, 32'h55AA1234, 0, 0, 1'b0);
        is_store = 1'b0; funct3 = 3'd2; addr = 32'h84; start = 1'b1;
        tick();
        start = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        reset = 1'b0;
        #1;
        model_ld = 32'd0;
        check("wr_reset_ld", load_data, 32'd0);
        tick();
        reset = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_rvalid = 1'b0;
        check("late_rv_nodone", {31'd0, done}, 32'd0);
        check("late_rv_ld", load_data, 32'd0);
        check("late_rv_idle", {31'd0, busy}, 32'd0);
        check("late_rv_noreq", {31'd0, mem_req}, 32'd0);
        $display("reset during WAIT_R, late rvalid ignored");

        for (int n = 0; n < 250; n++) begin
            logic [2:0] f3;
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
            else f3 = f3_pick[$urandom_range(0, 4)];
            do_op(1'($urandom_range(0, 1)), f3, $urandom, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        tick();
        check("final_nodone", {31'd0, done}, 32'd0);
        check("final_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
